txc_seg_fifo: RTL and testbench
===============================

TXC_SEG_FIFO -- requirements
Module: txc_seg_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving FIFO entries; it SHALL be a power of two, 2..64.
REQ-002 The block SHALL have parameter DATA_W, default 512, giving the segment data width in bits.
REQ-003 The block SHALL have port cclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port epb_valid, input, 1 bit: a segment from the EPB is presented this cycle.
REQ-006 The block SHALL have port epb_data, input, DATA_W bits: segment payload.
REQ-007 The block SHALL have ports epb_sop and epb_eop, input, 1 bit each: start and end of packet markers.
REQ-008 The block SHALL have port epb_crd_ret, output, 1 bit: one-cycle pulse returning one credit to the EPB.
REQ-009 The block SHALL have port txc_valid, output, 1 bit: the head segment is valid.
REQ-010 The block SHALL have port txc_ready, input, 1 bit: the TXC consumer accepts the head segment.
REQ-011 The block SHALL have ports txc_data (DATA_W bits), txc_sop and txc_eop (1 bit each), outputs: the head segment.
REQ-012 The block SHALL have port fill, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-013 The block SHALL have ports ovf_err and frm_err, output, 1 bit each: sticky overflow and framing errors.
REQ-014 The block SHALL have port err_clr, input, 1 bit: clears both sticky errors.

Function
REQ-015 Push SHALL occur when epb_valid=1, fill<DEPTH at the start of the cycle, and the framing FSM accepts the segment; a same-cycle pop SHALL NOT free space for that push.
REQ-016 Pop SHALL occur when txc_valid&txc_ready; no bypass: a segment pushed in cycle N SHALL first appear on txc_* in cycle N+1.
REQ-017 txc_valid SHALL equal (fill!=0); txc_data/sop/eop SHALL be stable while txc_valid&!txc_ready.
REQ-018 Simultaneous push and pop SHALL leave fill unchanged; pointers SHALL wrap modulo DEPTH.
REQ-019 A pop in cycle N SHALL produce epb_crd_ret=1 in cycle N+1 only; the EPB starts with DEPTH credits.
REQ-020 Framing FSM IDLE: sop&eop accepted, stay IDLE; sop&!eop accepted, go to IN_PKT; !sop sets frm_err, segment dropped, stay IDLE.
REQ-021 Framing FSM IN_PKT: !sop&eop accepted, go to IDLE; !sop&!eop accepted, stay; sop sets frm_err, segment dropped, stay IN_PKT.
REQ-022 A push attempt at fill==DEPTH SHALL set ovf_err and drop data with pointers unchanged; the FSM SHALL still advance as if the segment had been accepted.
REQ-023 err_clr SHALL clear the errors next cycle; a new error in the same cycle as err_clr SHALL win.

Reset
REQ-024 On rst_n low, asynchronously: pointers=0, fill=0, txc_valid=0, epb_crd_ret=0, ovf_err=0, frm_err=0, FSM=IDLE, and pkt_cnt=0 when present.
REQ-025 Reset mid-packet SHALL discard all stored contents and SHALL NOT return credits for them; the EPB re-initialises to DEPTH credits.
REQ-026 Data storage SHALL NOT require reset; txc_data is don't-care while txc_valid=0.

Configuration
REQ-027 With TXC_SEG_FIFO_STATS_EN defined, the block SHALL add output pkt_cnt[31:0], incremented on every pop with txc_eop=1 and wrapping from 0xFFFFFFFF to 0.
REQ-028 Without TXC_SEG_FIFO_STATS_EN, pkt_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Push 3 single-segment packets (sop=eop=1) with txc_ready=1 -> each appears 1 cycle after its push, 3 crd_ret pulses, fill returns to 0.
REQ-030 Hold txc_ready=0 and push 8 segments, then a 9th -> fill=8, ovf_err=1, the 9th is never output, and the first 8 drain in order.
REQ-031 Push at fill=8 with a same-cycle pop -> ovf_err=1, fill=7 afterwards, crd_ret pulses next cycle.
REQ-032 Push sop=0 in IDLE, then sop=1 inside a packet -> frm_err=1, both segments dropped, fill counts only accepted segments.
REQ-033 Assert rst_n low mid-packet with fill=5 -> all outputs reset immediately, no crd_ret, FSM=IDLE.
REQ-034 With STATS_EN, preload pkt_cnt near wrap and pop two eop segments -> pkt_cnt goes 0xFFFFFFFF then 0.

Source files
------------

// File: rtl/txc_seg_fifo.sv
// Segment FIFO between the EPB and the TXC, with packet framing checks and credit return.
// Latency: a segment pushed in cycle N is presented on txc_* in cycle N+1. No bypass path exists.
// Backpressure: the EPB is credit-based and each pop returns one credit. The TXC side is valid/ready.
// Optional: define TXC_SEG_FIFO_STATS_EN to add the pkt_cnt completed-packet counter.
module txc_seg_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 512
) (
  input  logic                     cclk,
  input  logic                     rst_n,
  input  logic                     epb_valid,
  input  logic [DATA_W-1:0]        epb_data,
  input  logic                     epb_sop,
  input  logic                     epb_eop,
  output logic                     epb_crd_ret,
  output logic                     txc_valid,
  input  logic                     txc_ready,
  output logic [DATA_W-1:0]        txc_data,
  output logic                     txc_sop,
  output logic                     txc_eop,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     ovf_err,
  output logic                     frm_err,
`ifdef TXC_SEG_FIFO_STATS_EN
  output logic [31:0]              pkt_cnt,
`endif
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {IDLE, IN_PKT} frm_state_e;

  // Each entry holds {sop, eop, data}.
  logic [DATA_W+1:0] mem_q [DEPTH];

  frm_state_e      state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     fill_q, fill_d;
  logic            crd_ret_q, crd_ret_d;
  logic            ovf_q, ovf_d;
  logic            frm_q, frm_d;
  logic            frm_ok, frm_bad, push, pop, ovf_set;
`ifdef TXC_SEG_FIFO_STATS_EN
  logic [31:0]     pkt_cnt_q, pkt_cnt_d;
`endif

  assign txc_valid   = (fill_q != '0);
  assign txc_data    = mem_q[rd_ptr_q][DATA_W-1:0];
  assign txc_sop     = mem_q[rd_ptr_q][DATA_W+1];
  assign txc_eop     = mem_q[rd_ptr_q][DATA_W];
  assign fill        = fill_q;
  assign epb_crd_ret = crd_ret_q;
  assign ovf_err     = ovf_q;
  assign frm_err     = frm_q;
`ifdef TXC_SEG_FIFO_STATS_EN
  assign pkt_cnt     = pkt_cnt_q;
`endif

  // Framing FSM, push/pop decisions, occupancy and sticky error next-state.
  always_comb begin
    state_d   = state_q;
    frm_ok    = 1'b0;
    frm_bad   = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
`ifdef TXC_SEG_FIFO_STATS_EN
    pkt_cnt_d = pkt_cnt_q;
`endif

    if (epb_valid) begin
      unique case (state_q)
        IDLE: begin
          if (epb_sop) begin
            frm_ok = 1'b1;
            if (!epb_eop) state_d = IN_PKT;
          end else begin
            frm_bad = 1'b1;
          end
        end
        IN_PKT: begin
          if (!epb_sop) begin
            frm_ok = 1'b1;
            if (epb_eop) state_d = IDLE;
          end else begin
            frm_bad = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Space is judged on the occupancy at the start of the cycle, so a same-cycle
    // pop never makes room. A well-framed segment that hits a full FIFO still moves
    // the FSM, which keeps framing aligned with the EPB's view of the stream.
    push    = frm_ok && (fill_q != FULL_CNT);
    ovf_set = frm_ok && (fill_q == FULL_CNT);
    pop     = txc_valid && txc_ready;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      fill_d = fill_q + CNT_ONE;
    else if (!push && pop) fill_d = fill_q - CNT_ONE;

    crd_ret_d = pop;

    // A new error in the same cycle as err_clr takes priority over the clear.
    ovf_d = ovf_set ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    frm_d = frm_bad ? 1'b1 : (err_clr ? 1'b0 : frm_q);

`ifdef TXC_SEG_FIFO_STATS_EN
    if (pop && txc_eop) pkt_cnt_d = pkt_cnt_q + 32'd1;
`endif
  end

  // Control state; reset drops all stored segments without returning their credits.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      crd_ret_q <= 1'b0;
      ovf_q     <= 1'b0;
      frm_q     <= 1'b0;
`ifdef TXC_SEG_FIFO_STATS_EN
      pkt_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      crd_ret_q <= crd_ret_d;
      ovf_q     <= ovf_d;
      frm_q     <= frm_d;
`ifdef TXC_SEG_FIFO_STATS_EN
      pkt_cnt_q <= pkt_cnt_d;
`endif
    end
  end

  // Segment storage, which is not reset. Contents are only observed while fill is non-zero.
  always_ff @(posedge cclk) begin
    if (push) mem_q[wr_ptr_q] <= {epb_sop, epb_eop, epb_data};
  end

endmodule

// File: tb/tb_txc_seg_fifo.sv
module tb_txc_seg_fifo;

  logic         cclk = 1'b0;
  logic         rst_n;
  logic         epb_valid;
  logic [511:0] epb_data;
  logic         epb_sop, epb_eop;
  logic         epb_crd_ret;
  logic         txc_valid;
  logic         txc_ready;
  logic [511:0] txc_data;
  logic         txc_sop, txc_eop;
  logic [3:0]   fill;
  logic         ovf_err, frm_err;
  logic         err_clr;
`ifdef TXC_SEG_FIFO_STATS_EN
  logic [31:0]  pkt_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  txc_seg_fifo #(.DEPTH(8), .DATA_W(512)) dut (
    .cclk        (cclk),
    .rst_n       (rst_n),
    .epb_valid   (epb_valid),
    .epb_data    (epb_data),
    .epb_sop     (epb_sop),
    .epb_eop     (epb_eop),
    .epb_crd_ret (epb_crd_ret),
    .txc_valid   (txc_valid),
    .txc_ready   (txc_ready),
    .txc_data    (txc_data),
    .txc_sop     (txc_sop),
    .txc_eop     (txc_eop),
    .fill        (fill),
    .ovf_err     (ovf_err),
    .frm_err     (frm_err),
`ifdef TXC_SEG_FIFO_STATS_EN
    .pkt_cnt     (pkt_cnt),
`endif
    .err_clr     (err_clr)
  );

  always #5 cclk = ~cclk;

  function automatic logic [511:0] pat(input logic [31:0] v);
    return {16{v}};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic s, input logic e, input logic [31:0] d);
    epb_valid = v;
    epb_sop   = s;
    epb_eop   = e;
    epb_data  = pat(d);
  endtask

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; txc_ready = 1'b0; err_clr = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 32'h0);
    #12;
    chk("rst_fill", 512'(fill), 512'(0));
    chk("rst_valid", 512'(txc_valid), 512'(0));
    chk("rst_crd", 512'(epb_crd_ret), 512'(0));
    chk("rst_ovf", 512'(ovf_err), 512'(0));
    chk("rst_frm", 512'(frm_err), 512'(0));
    rst_n = 1'b1;
    tick();

    // Three single-segment packets with the consumer always ready.
    txc_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 1'b1, 32'h10 + i);
      tick();
      chk("t1_valid", 512'(txc_valid), 512'(1));
      chk("t1_data", txc_data, pat(32'h10 + i));
      chk("t1_fill1", 512'(fill), 512'(1));
      chk("t1_crd_lo", 512'(epb_crd_ret), 512'(0));
      drv(1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      chk("t1_crd", 512'(epb_crd_ret), 512'(1));
      chk("t1_fill0", 512'(fill), 512'(0));
      tick();
      chk("t1_crd_once", 512'(epb_crd_ret), 512'(0));
    end

    // Fill to capacity, then overflow with a ninth segment that must vanish.
    txc_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 1'b1, 1'b1, 32'h100 + i);
      tick();
    end
    chk("t2_fill8", 512'(fill), 512'(8));
    chk("t2_head", txc_data, pat(32'h100));
    chk("t2_ovf_lo", 512'(ovf_err), 512'(0));
    drv(1'b1, 1'b1, 1'b1, 32'h999);
    tick();
    chk("t2_ovf", 512'(ovf_err), 512'(1));
    chk("t2_fill_full", 512'(fill), 512'(8));
    drv(1'b0, 1'b0, 1'b0, 32'h0);
    txc_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_order", txc_data, pat(32'h100 + i));
      tick();
      chk("t2_crd", 512'(epb_crd_ret), 512'(1));
    end
    chk("t2_fill0", 512'(fill), 512'(0));
    chk("t2_valid0", 512'(txc_valid), 512'(0));
    txc_ready = 1'b0;
    tick();
    chk("t2_crd_lo", 512'(epb_crd_ret), 512'(0));
    chk("t2_ovf_sticky", 512'(ovf_err), 512'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t2_ovf_clr", 512'(ovf_err), 512'(0));

    // Full FIFO with a push and a pop in the same cycle: the pop does not make room.
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 1'b1, 1'b1, 32'h200 + i);
      tick();
    end
    drv(1'b1, 1'b1, 1'b1, 32'h777);
    txc_ready = 1'b1;
    tick();
    chk("t3_ovf", 512'(ovf_err), 512'(1));
    chk("t3_fill7", 512'(fill), 512'(7));
    chk("t3_crd", 512'(epb_crd_ret), 512'(1));
    chk("t3_head", txc_data, pat(32'h201));
    drv(1'b0, 1'b0, 1'b0, 32'h0);
    txc_ready = 1'b0;
    tick();
    chk("t3_crd_lo", 512'(epb_crd_ret), 512'(0));
    chk("t3_hold_data", txc_data, pat(32'h201));
    txc_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk("t3_order", txc_data, pat(32'h200 + i));
      tick();
    end
    chk("t3_fill0", 512'(fill), 512'(0));
    txc_ready = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Framing errors: sop=0 while idle, and sop=1 inside a packet.
    drv(1'b1, 1'b0, 1'b1, 32'h300);
    tick();
    chk("t4_frm_idle", 512'(frm_err), 512'(1));
    chk("t4_drop_idle", 512'(fill), 512'(0));
    drv(1'b0, 1'b0, 1'b0, 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_frm_clr", 512'(frm_err), 512'(0));
    drv(1'b1, 1'b1, 1'b0, 32'h301);
    tick();
    chk("t4_sop_acc", 512'(fill), 512'(1));
    chk("t4_frm_lo", 512'(frm_err), 512'(0));
    drv(1'b1, 1'b1, 1'b1, 32'h302);
    tick();
    chk("t4_frm_inpkt", 512'(frm_err), 512'(1));
    chk("t4_drop_inpkt", 512'(fill), 512'(1));
    drv(1'b1, 1'b0, 1'b1, 32'h303);
    tick();
    chk("t4_eop_acc", 512'(fill), 512'(2));
    drv(1'b1, 1'b0, 1'b0, 32'h304);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_wins", 512'(frm_err), 512'(1));
    chk("t4_fill2", 512'(fill), 512'(2));
    drv(1'b0, 1'b0, 1'b0, 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_frm_clr2", 512'(frm_err), 512'(0));
    txc_ready = 1'b1;
    chk("t4_d0", txc_data, pat(32'h301));
    chk("t4_sop0", 512'(txc_sop), 512'(1));
    chk("t4_eop0", 512'(txc_eop), 512'(0));
    tick();
    chk("t4_d1", txc_data, pat(32'h303));
    chk("t4_sop1", 512'(txc_sop), 512'(0));
    chk("t4_eop1", 512'(txc_eop), 512'(1));
    tick();
    chk("t4_fill0", 512'(fill), 512'(0));
    txc_ready = 1'b0;

    // Reset in the middle of a packet with five segments stored.
    drv(1'b1, 1'b1, 1'b0, 32'h400);
    tick();
    for (int i = 1; i < 6; i++) begin
      drv(1'b1, 1'b0, 1'b0, 32'h400 + i);
      tick();
    end
    drv(1'b1, 1'b1, 1'b1, 32'h4ff);
    tick();
    chk("t5_frm_pre", 512'(frm_err), 512'(1));
    chk("t5_fill6", 512'(fill), 512'(6));
    drv(1'b0, 1'b0, 1'b0, 32'h0);
    txc_ready = 1'b1;
    tick();
    txc_ready = 1'b0;
    chk("t5_fill5", 512'(fill), 512'(5));
    chk("t5_crd_pre", 512'(epb_crd_ret), 512'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_fill", 512'(fill), 512'(0));
    chk("t5_rst_valid", 512'(txc_valid), 512'(0));
    chk("t5_rst_crd", 512'(epb_crd_ret), 512'(0));
    chk("t5_rst_frm", 512'(frm_err), 512'(0));
    chk("t5_rst_ovf", 512'(ovf_err), 512'(0));
    tick();
    chk("t5_rst_crd_hold", 512'(epb_crd_ret), 512'(0));
    rst_n = 1'b1;
    tick();
    chk("t5_no_crd", 512'(epb_crd_ret), 512'(0));
    drv(1'b1, 1'b1, 1'b1, 32'h500);
    tick();
    chk("t5_idle_fill", 512'(fill), 512'(1));
    chk("t5_idle_frm", 512'(frm_err), 512'(0));
    chk("t5_idle_data", txc_data, pat(32'h500));
    drv(1'b0, 1'b0, 1'b0, 32'h0);
    txc_ready = 1'b1;
    tick();
    chk("t5_crd", 512'(epb_crd_ret), 512'(1));
    chk("t5_fill0", 512'(fill), 512'(0));
    txc_ready = 1'b0;

`ifdef TXC_SEG_FIFO_STATS_EN
    // Packet counter wrap: preload near the top and pop two end-of-packet segments.
    drv(1'b1, 1'b1, 1'b1, 32'h600);
    tick();
    drv(1'b1, 1'b1, 1'b1, 32'h601);
    tick();
    drv(1'b0, 1'b0, 1'b0, 32'h0);
    force dut.pkt_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.pkt_cnt_q;
    #1;
    chk("t6_preload", 512'(pkt_cnt), 512'(32'hFFFF_FFFE));
    txc_ready = 1'b1;
    tick();
    chk("t6_cnt_max", 512'(pkt_cnt), 512'(32'hFFFF_FFFF));
    tick();
    chk("t6_cnt_wrap", 512'(pkt_cnt), 512'(0));
    txc_ready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
